spi_aes_rx_frontend: RTL

- Serial-side receiver/transmitter for the AES core, directly downstream of the SPI master.
- Deserialises a 128-bit message, then a 128/192/256-bit key, from MOSI while CS is low.
- Issues a one-cycle start to the AES core, waits for its done, then serialises the 128-bit result back on MISO.
- Runs on the SPI bit clock: one serial bit per enabled clk cycle.

---
 rtl/spi_aes_pkg.sv | 43 ++++
 rtl/spi_aes_rx_frontend_piso.sv | 45 ++++
 rtl/spi_aes_rx_frontend.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_aes_pkg.sv
// -----------------------------------------------------------------------------
// spi_aes_pkg
// Shared definitions for the SPI-side AES front end.
//   - state_t     : frame-level FSM states
//   - key_size_t  : encodings of the 2-bit key size field
//   - MSG_W       : message / result width in bits
//   - key_bits()  : key length in bits for a size code (illegal code maps to 128)
// -----------------------------------------------------------------------------
package spi_aes_pkg;

  localparam int MSG_W = 128;

  typedef enum logic [1:0] {
    SZ_128 = 2'b00,
    SZ_192 = 2'b01,
    SZ_256 = 2'b10,
    SZ_ILL = 2'b11
  } key_size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_MSG,
    ST_RX_KEY,
    ST_START,
    ST_WAIT_CORE,
    ST_TX,
    ST_DONE,
    ST_ERR
  } state_t;

  // Key length for a size code. The illegal code never reaches the key
  // receive path, so its return value only has to be a safe constant.
  function automatic logic [8:0] key_bits(input logic [1:0] sz);
    logic [8:0] len;
    case (sz)
      SZ_192:  len = 9'd192;
      SZ_256:  len = 9'd256;
      default: len = 9'd128;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/spi_aes_rx_frontend_piso.sv
// -----------------------------------------------------------------------------
// spi_piso_128
// 128-bit parallel-load, LSB-first shift-out register with a registered
// serial output.
//   clk, reset (sync, active-low), enable (clock enable)
//   load  : capture data; sout shows data[0] from the next cycle
//   shift : advance one bit; sout shows the next more-significant bit
//   data  : parallel input word
//   sout  : registered serial output; returns to 0 on any enabled cycle
//           with neither load nor shift
// -----------------------------------------------------------------------------
module spi_piso_128
  import spi_aes_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             shift,
  input  logic [MSG_W-1:0] data,
  output logic             sout
);

  // sr holds the bits still to be presented; bit 0 of the word goes straight
  // into sout on load so the first output cycle already carries it.
  logic [MSG_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr   <= '0;
      sout <= 1'b0;
    end else if (enable) begin
      if (load) begin
        sr   <= {1'b0, data[MSG_W-1:1]};
        sout <= data[0];
      end else if (shift) begin
        sr   <= {1'b0, sr[MSG_W-1:1]};
        sout <= sr[0];
      end else begin
        sout <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_aes_rx_frontend.sv
// -----------------------------------------------------------------------------
// spi_aes_rx_frontend
// Serial front end for the AES core, running on the SPI bit clock (one bit per
// enabled clk cycle). While cs is low it receives a 128-bit message and then a
// 128/192/256-bit key LSB first on mosi, pulses core_start, waits for
// core_done and shifts the 128-bit result out LSB first on miso.
//
// Ports
//   clk, reset (sync, active-low, wins over enable), enable (clock enable)
//   cs (active-low chip select), mosi (serial in), size (key size code)
//   miso (registered serial out)
//   core_start, core_msg, core_key (left-aligned), core_size -> AES core
//   core_done, core_result                                   <- AES core
//   busy, frame_done, err                                    status
//
// Core handshake: core_start is high for the single START cycle; afterwards
// the first WAIT_CORE cycle with core_done=1 captures core_result, which is
// only sampled in that cycle. core_done may be a pulse or a level.
//
// The FSM state is kept in the 'state' signal (type state_t) for observation.
// -----------------------------------------------------------------------------
module spi_aes_rx_frontend #(
  parameter int MSG_W     = 128,
  parameter int KEY_MAX_W = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 cs,
  input  logic                 mosi,
  input  logic [1:0]           size,
  output logic                 miso,
  output logic                 core_start,
  output logic [MSG_W-1:0]     core_msg,
  output logic [KEY_MAX_W-1:0] core_key,
  output logic [1:0]           core_size,
  input  logic                 core_done,
  input  logic [MSG_W-1:0]     core_result,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err
);

  import spi_aes_pkg::*;

  localparam int MSG_IDX_W = $clog2(MSG_W);
  localparam int KEY_IDX_W = $clog2(KEY_MAX_W);

  state_t state, state_d;

  // Bit counter: message bit, key bit or TX bit index depending on state.
  logic [8:0] cnt;

  logic start_frame;
  logic cnt_clr;
  logic cnt_inc;
  logic msg_wr;
  logic key_wr;
  logic piso_load;
  logic piso_shift;

  logic [8:0]           key_len;
  logic [KEY_IDX_W-1:0] key_idx;
  logic [KEY_MAX_W-1:0] key_keep;

  assign key_len = key_bits(core_size);

  // Key bit k lands at KEY_MAX_W-K+k so the key ends up left-aligned.
  assign key_idx = KEY_IDX_W'(9'(KEY_MAX_W) - key_len + cnt);

  // Bits below KEY_MAX_W-K are cleared when a frame starts; the rest are
  // overwritten by the incoming key anyway.
  assign key_keep = {KEY_MAX_W{1'b1}} << (9'(KEY_MAX_W) - key_bits(size));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else if (enable) begin
      state <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state;
    start_frame = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    msg_wr      = 1'b0;
    key_wr      = 1'b0;
    piso_load   = 1'b0;
    piso_shift  = 1'b0;
    core_start  = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    err         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!cs) begin
          start_frame = 1'b1;
          if (size == SZ_ILL) begin
            state_d = ST_ERR;
          end else begin
            // This cycle's mosi is already message bit 0.
            msg_wr  = 1'b1;
            cnt_inc = 1'b1;
            state_d = ST_RX_MSG;
          end
        end
      end

      ST_RX_MSG: begin
        busy = 1'b1;
        if (cs) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          msg_wr = 1'b1;
          if (cnt == 9'(MSG_W - 1)) begin
            cnt_clr = 1'b1;
            state_d = ST_RX_KEY;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end

      ST_RX_KEY: begin
        busy = 1'b1;
        if (cs) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          key_wr = 1'b1;
          if (cnt == key_len - 9'd1) begin
            cnt_clr = 1'b1;
            state_d = ST_START;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end

      ST_START: begin
        // The pulse is tied to the state, so an abort here still issues it.
        busy       = 1'b1;
        core_start = 1'b1;
        state_d    = cs ? ST_IDLE : ST_WAIT_CORE;
      end

      ST_WAIT_CORE: begin
        busy = 1'b1;
        if (cs) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (core_done) begin
          piso_load = 1'b1;
          state_d   = ST_TX;
        end
      end

      ST_TX: begin
        busy = 1'b1;
        if (cs) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt == 9'(MSG_W - 1)) begin
          // No shift on the last bit: miso drops back to 0 in DONE.
          cnt_clr = 1'b1;
          state_d = ST_DONE;
        end else begin
          piso_shift = 1'b1;
          cnt_inc    = 1'b1;
        end
      end

      ST_DONE: begin
        frame_done = 1'b1;
        if (cs) begin
          state_d = ST_IDLE;
        end
      end

      ST_ERR: begin
        err = 1'b1;
        if (cs) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter and receive registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      core_msg  <= '0;
      core_key  <= '0;
      core_size <= '0;
    end else if (enable) begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 9'd1;
      end

      if (start_frame) begin
        core_size <= size;
        if (size != SZ_ILL) begin
          core_key <= core_key & key_keep;
        end
      end

      if (msg_wr) begin
        core_msg[cnt[MSG_IDX_W-1:0]] <= mosi;
      end

      if (key_wr) begin
        core_key[key_idx] <= mosi;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result serialiser
  // ---------------------------------------------------------------------------
  spi_piso_128 u_piso (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .load   (piso_load),
    .shift  (piso_shift),
    .data   (core_result),
    .sout   (miso)
  );

endmodule
